// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU background fetch path: the fetch FSM
// encoding, the fixed memory-map constants and the address helpers.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NT   = 3'd1,
    ST_AT   = 3'd2,
    ST_PTL  = 3'd3,
    ST_PTH  = 3'd4
  } state_t;

  localparam logic [13:0] NT_BASE     = 14'h2000;
  localparam logic [13:0] AT_OFFSET   = 14'h03C0;
  localparam logic [13:0] PT_PLANE_HI = 14'h0008;

  // Nametable byte address for the tile selected by v.
  function automatic logic [13:0] f_nt_addr(input logic [14:0] v);
    return NT_BASE | {2'b00, v[11:0]};
  endfunction

  // Attribute byte address: one byte covers a 4x4 tile block.
  function automatic logic [13:0] f_at_addr(input logic [14:0] v);
    return NT_BASE | AT_OFFSET | {2'b00, v[11:10], 10'd0}
         | {8'd0, v[9:7], 3'd0} | {11'd0, v[4:2]};
  endfunction

  // Low-plane pattern address; the high plane is this value | PT_PLANE_HI.
  function automatic logic [13:0] f_pt_addr(input logic sel, input logic [7:0] nt,
                                            input logic [2:0] fine_y);
    return {1'b0, sel, nt, 1'b0, fine_y};
  endfunction

  // Pick the 2-bit palette field for the 2x2 quadrant the tile sits in.
  function automatic logic [1:0] f_at_bits(input logic [7:0] at_byte, input logic [14:0] v);
    logic [7:0] shifted;
    shifted = at_byte >> {v[6], v[1], 1'b0};
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/ppu_vaddr_inc.sv
// Scroll address increment: coarse X step with horizontal nametable
// toggle, and Y step with fine/coarse carry and vertical nametable toggle.
module ppu_vaddr_inc (
  input  logic [14:0] v,
  input  logic        inc_x,
  input  logic        inc_y,
  output logic [14:0] v_next
);

  // Fields are disjoint, so both steps can be applied in the same pass.
  always_comb begin
    v_next = v;
    if (inc_x) begin
      if (v[4:0] == 5'd31) begin
        v_next[4:0] = 5'd0;
        v_next[10]  = ~v[10];
      end else begin
        v_next[4:0] = v[4:0] + 5'd1;
      end
    end
    if (inc_y) begin
      if (v[14:12] != 3'd7) begin
        v_next[14:12] = v[14:12] + 3'd1;
      end else begin
        v_next[14:12] = 3'd0;
        // Row 29 is the last visible row; rows 30/31 hold attributes and
        // wrap without switching nametables.
        if (v[9:5] == 5'd29) begin
          v_next[9:5] = 5'd0;
          v_next[11]  = ~v[11];
        end else if (v[9:5] == 5'd31) begin
          v_next[9:5] = 5'd0;
        end else begin
          v_next[9:5] = v[9:5] + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetcher: walks NT -> AT -> PTL -> PTH for each tile of a
// line, two enabled cycles per access, and presents each finished tile.
module ppu_bg_fetch
  import ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start_line,
  input  logic [14:0] v_in,
  input  logic        bg_pat_sel,
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_rd_data,
  output logic [7:0]  tile_lo,
  output logic [7:0]  tile_hi,
  output logic [1:0]  tile_at,
  output logic        tile_valid,
  output logic [14:0] v_out,
  output logic        busy,
  output logic        line_done
);

  localparam int TW = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
  localparam logic [TW-1:0] LAST_TILE = TW'(TILES_PER_LINE - 1);

  state_t          r_state;
  logic            r_phase;
  logic [TW-1:0]   r_tile;
  logic [14:0]     r_v;
  logic [7:0]      r_nt;
  logic [7:0]      r_at;
  logic [7:0]      r_lo;
  logic [13:0]     r_vram_addr;
  logic [7:0]      r_tile_lo;
  logic [7:0]      r_tile_hi;
  logic [1:0]      r_tile_at;
  logic            r_tile_valid;
  logic            r_busy;
  logic            r_line_done;

  logic            w_last;
  logic [14:0]     w_v_next;

  assign w_last = (r_tile == LAST_TILE);

  // The final tile of a line takes the Y step in place of the X step.
  ppu_vaddr_inc u_vaddr_inc (
    .v      (r_v),
    .inc_x  (~w_last),
    .inc_y  (w_last),
    .v_next (w_v_next)
  );

  // Fetch sequencer; each access presents its address in phase 0 and
  // captures the returned byte at the end of phase 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= 1'b0;
      r_tile       <= '0;
      r_v          <= '0;
      r_nt         <= '0;
      r_at         <= '0;
      r_lo         <= '0;
      r_vram_addr  <= '0;
      r_tile_lo    <= '0;
      r_tile_hi    <= '0;
      r_tile_at    <= '0;
      r_tile_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_tile_valid <= 1'b0;
      r_line_done  <= 1'b0;
      if (en) begin
        // A tile finishing on this edge is delivered even if a restart
        // arrives at the same time.
        if (r_state == ST_PTH && r_phase) begin
          r_tile_lo    <= r_lo;
          r_tile_hi    <= vram_rd_data;
          r_tile_at    <= f_at_bits(r_at, r_v);
          r_tile_valid <= 1'b1;
        end
        if (start_line) begin
          r_v         <= v_in;
          r_state     <= ST_NT;
          r_phase     <= 1'b0;
          r_tile      <= '0;
          r_busy      <= 1'b1;
          r_vram_addr <= f_nt_addr(v_in);
        end else if (r_state != ST_IDLE && !r_phase) begin
          r_phase <= 1'b1;
        end else if (r_phase) begin
          r_phase <= 1'b0;
          case (r_state)
            ST_NT: begin
              r_nt        <= vram_rd_data;
              r_state     <= ST_AT;
              r_vram_addr <= f_at_addr(r_v);
            end
            ST_AT: begin
              r_at        <= vram_rd_data;
              r_state     <= ST_PTL;
              r_vram_addr <= f_pt_addr(bg_pat_sel, r_nt, r_v[14:12]);
            end
            ST_PTL: begin
              r_lo        <= vram_rd_data;
              r_state     <= ST_PTH;
              r_vram_addr <= r_vram_addr | PT_PLANE_HI;
            end
            ST_PTH: begin
              r_v <= w_v_next;
              if (w_last) begin
                r_state     <= ST_IDLE;
                r_tile      <= '0;
                r_busy      <= 1'b0;
                r_line_done <= 1'b1;
              end else begin
                r_state     <= ST_NT;
                r_tile      <= r_tile + 1'b1;
                r_vram_addr <= f_nt_addr(w_v_next);
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign vram_addr  = r_vram_addr;
  assign tile_lo    = r_tile_lo;
  assign tile_hi    = r_tile_hi;
  assign tile_at    = r_tile_at;
  assign tile_valid = r_tile_valid;
  assign v_out      = r_v;
  assign busy       = r_busy;
  assign line_done  = r_line_done;

endmodule

// File: doc/ppu_bg_fetch.md
PPU_BG_FETCH -- requirements
Module: ppu_bg_fetch

Interface
REQ-001 SHALL have parameter TILES_PER_LINE, 32, tiles fetched per start_line.
REQ-002 SHALL have port clk  input  1  system clock; the single clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port en  input  1  PPU dot enable; all state advances only when en=1.
REQ-005 SHALL have port start_line  input  1  single-cycle pulse that begins a line fetch.
REQ-006 SHALL have port v_in  input  15  scroll address {fine_y[2:0], nt[1:0], coarse_y[4:0], coarse_x[4:0]}, loaded on start_line.
REQ-007 SHALL have port bg_pat_sel  input  1  pattern table base: 0 selects 0x0000, 1 selects 0x1000.
REQ-008 SHALL have port vram_addr  output  14  read address to the PPU memory controller.
REQ-009 SHALL have port vram_rd_data  input  8  controller read data, valid one clk after vram_addr.
REQ-010 SHALL have port tile_lo, tile_hi  output  8 each  pattern planes of the completed tile.
REQ-011 SHALL have port tile_at  output  2  palette bits of the completed tile.
REQ-012 SHALL have port tile_valid  output  1  one-clk pulse when tile outputs update.
REQ-013 SHALL have port v_out  output  15  current scroll address.
REQ-014 SHALL have ports busy and line_done  output  1 each  fetch in progress; one-clk end-of-line pulse.
REQ-015 SHALL never write memory; no write-enable is driven.

Function
REQ-016 SHALL implement FSM states IDLE, NT, AT, PTL, PTH; each non-IDLE state lasts 2 enabled cycles: phase 0 drives the address, phase 1 captures vram_rd_data.
REQ-017 IDLE -> NT on start_line; v loaded from v_in; tile counter cleared; busy=1 from the next cycle.
REQ-018 Sequence: NT -> AT -> PTL -> PTH -> NT (next tile), or -> IDLE after tile TILES_PER_LINE-1.
REQ-019 NT address SHALL be 0x2000 | v[11:0].
REQ-020 AT address SHALL be 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
REQ-021 PTL address SHALL be bg_pat_sel<<12 | nt_byte<<4 | v[14:12]; PTH address SHALL equal PTL address | 0x8.
REQ-022 tile_at SHALL be (at_byte >> {v[6], v[1], 1'b0})[1:0], evaluated with the v used for that tile.
REQ-023 At PTH phase 1: tile_lo, tile_hi and tile_at update together, tile_valid pulses, and coarse X increments; coarse X 31 -> 0 toggles v[10].
REQ-024 After the last tile: Y increments; fine_y 7 -> 0 carries into coarse Y; coarse Y 29 -> 0 toggles v[11]; coarse Y 31 -> 0 without toggle; line_done pulses, busy=0, state=IDLE.
REQ-025 en=0 SHALL freeze state, vram_addr, counters and outputs; tile_valid and line_done SHALL NOT pulse when en=0.
REQ-026 start_line while busy SHALL abort the current line, reload v_in, and restart at NT phase 0; no line_done for the aborted line.
REQ-027 start_line coincident with the final PTH phase 1 SHALL take precedence: restart, no line_done; the final tile's tile_valid still pulses.
REQ-028 vram_addr SHALL hold its last value in IDLE.

Reset
REQ-029 rst_n=0 at a clk edge SHALL force IDLE and zero vram_addr, v_out, tile_lo, tile_hi, tile_at, tile_valid, busy, line_done and the tile counter, regardless of en or of a fetch in progress.
REQ-030 start_line during reset SHALL be ignored.

Structure
REQ-031 Shared package ppu_pkg SHALL hold the FSM state encoding, NT_BASE=0x2000, AT_OFFSET=0x3C0 and PT_PLANE_HI=0x8.
REQ-032 Scroll-increment logic SHALL be a combinational sub-module ppu_vaddr_inc (inputs v, inc_x, inc_y; output next v).

Verification
REQ-033 v_in=0x0000, sel=0, en=1, start_line, mem[0x2000]=0x12, mem[0x23C0]=0xE4, mem[0x0120]=0xAA, mem[0x0128]=0x55 -> addresses 0x2000, 0x23C0, 0x0120, 0x0128; first tile_valid 8 clks after start with lo=0xAA, hi=0x55, at=0.
REQ-034 Coarse X wrap: v_in=0x001F, TILES_PER_LINE=2 -> second NT address 0x2400; line_done pulses; v_out=0x1400.
REQ-035 Y wrap: v_in=0x73A0 (fine_y=7, coarse_y=29) -> v_out after line has fine_y=0, coarse_y=0, v[11]=1.
REQ-036 en toggled 1-0-1 every clk -> identical address/data sequence to REQ-033 at half rate; no extra tile_valid pulses.
REQ-037 start_line re-pulsed at tile 5 with v_in=0x0040 -> next address 0x2040; no line_done until 32 further tiles complete.
REQ-038 rst_n=0 mid-PTL -> next cycle busy=0, all outputs zero; an NT fetch follows only the next start_line.
